// File: rtl/btb_update.sv
// BTB update engine: turns branch resolutions into BTB entry/LRU writes via a
// read-modify-write of the set metadata, and sweeps the whole table on flush.
module btb_update #(
   parameter int WAYS = 4,
   parameter int SETS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [31:0] res_pc,
   input  logic [31:0] res_target,
   input  logic        res_taken,
   input  logic        flush,
   output logic        meta_rd_en,
   output logic [9:0]  meta_rd_index,
   input  logic [79:0] meta_tag,
   input  logic [3:0]  meta_valid,
   input  logic [7:0]  meta_pred,
   input  logic [2:0]  meta_lru,
   output logic        wr_en,
   output logic [9:0]  wr_index,
   output logic [3:0]  wr_way_mask,
   output logic [19:0] wr_tag,
   output logic [31:0] wr_target,
   output logic [1:0]  wr_pred,
   output logic        wr_valid,
   output logic        lru_wr_en,
   output logic [2:0]  lru_wr_data,
   output logic        flush_busy,
   output logic [15:0] alloc_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;
   localparam logic [9:0] LAST_IDX = 10'(SETS - 1);

   logic [1:0]  state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  idx_q, idx_d;
   logic [19:0] tag_q, tag_d;
   logic [31:0] target_q, target_d;
   logic        taken_q, taken_d;
   logic [15:0] alloc_q, alloc_d;

   logic [3:0]  hit_vec;
   logic        hit;
   logic [1:0]  hit_way;
   logic [1:0]  inv_way;
   logic        any_inv;
   logic [1:0]  victim_way;
   logic [1:0]  sel_way;
   logic [1:0]  old_pred;
   logic [1:0]  new_pred;
   logic [2:0]  lru_upd;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_hit
         assign hit_vec[gi] = meta_valid[gi] && (meta_tag[20*gi +: 20] == tag_q);
      end
   endgenerate

   assign hit = |hit_vec;

   // Downward scans leave the lowest matching / invalid way selected.
   always_comb begin
      hit_way = 2'd0;
      inv_way = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (hit_vec[w])
            hit_way = 2'(w);
         if (!meta_valid[w])
            inv_way = 2'(w);
      end
   end

   assign any_inv    = ~&meta_valid;
   assign victim_way = meta_lru[0] ? (meta_lru[2] ? 2'd3 : 2'd2)
                                   : (meta_lru[1] ? 2'd1 : 2'd0);
   assign sel_way    = hit ? hit_way : (any_inv ? inv_way : victim_way);
   assign old_pred   = meta_pred[2*hit_way +: 2];

   always_comb begin
      if (taken_q)
         new_pred = (old_pred == 2'd3) ? 2'd3 : old_pred + 2'd1;
      else
         new_pred = (old_pred == 2'd0) ? 2'd0 : old_pred - 2'd1;
   end

   // Point the tree away from the way just written; lru bit order is {b2,b1,b0}.
   always_comb begin
      if (!sel_way[1])
         lru_upd = {meta_lru[2], (sel_way == 2'd0), 1'b1};
      else
         lru_upd = {(sel_way == 2'd2), meta_lru[1], 1'b0};
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      tag_d         = tag_q;
      target_d      = target_q;
      taken_d       = taken_q;
      alloc_d       = alloc_q;
      res_ready     = 1'b0;
      meta_rd_en    = 1'b0;
      meta_rd_index = 10'd0;
      wr_en         = 1'b0;
      wr_index      = 10'd0;
      wr_way_mask   = 4'd0;
      wr_tag        = 20'd0;
      wr_target     = 32'd0;
      wr_pred       = 2'd0;
      wr_valid      = 1'b0;
      lru_wr_en     = 1'b0;
      lru_wr_data   = 3'd0;
      flush_busy    = 1'b0;

      case (state_q)
         S_IDLE: begin
            res_ready = !flush;
            if (flush) begin
               state_d = S_FLUSH;
               cnt_d   = 10'd0;
            end else if (res_valid) begin
               state_d  = S_READ;
               idx_d    = res_pc[11:2];
               tag_d    = res_pc[31:12];
               target_d = res_target;
               taken_d  = res_taken;
            end
         end
         S_READ: begin
            meta_rd_en    = 1'b1;
            meta_rd_index = idx_q;
            state_d       = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_IDLE;
            if (hit || taken_q) begin
               wr_en       = 1'b1;
               wr_index    = idx_q;
               wr_way_mask = 4'b0001 << sel_way;
               wr_tag      = tag_q;
               wr_target   = target_q;
               wr_pred     = hit ? new_pred : 2'b10;
               wr_valid    = 1'b1;
               lru_wr_en   = 1'b1;
               lru_wr_data = lru_upd;
               if (!hit && alloc_q != 16'hFFFF)
                  alloc_d = alloc_q + 16'd1;
            end
         end
         default: begin
            flush_busy  = 1'b1;
            wr_en       = 1'b1;
            wr_index    = cnt_q;
            wr_way_mask = 4'hF;
            lru_wr_en   = 1'b1;
            cnt_d       = cnt_q + 10'd1;
            if (cnt_q == LAST_IDX) begin
               state_d = S_IDLE;
               cnt_d   = 10'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 10'd0;
         idx_q    <= 10'd0;
         tag_q    <= 20'd0;
         target_q <= 32'd0;
         taken_q  <= 1'b0;
         alloc_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         taken_q  <= taken_d;
         alloc_q  <= alloc_d;
      end
   end

   assign alloc_count = alloc_q;

endmodule

// File: tb/tb_btb_update.sv
// Directed bench for btb_update: allocate, hit, victim, not-taken miss,
// flush-vs-request priority and reset during a flush sweep.
module tb_btb_update;

   logic        clk;
   logic        rst;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_pc;
   logic [31:0] res_target;
   logic        res_taken;
   logic        flush;
   logic        meta_rd_en;
   logic [9:0]  meta_rd_index;
   logic [79:0] meta_tag;
   logic [3:0]  meta_valid;
   logic [7:0]  meta_pred;
   logic [2:0]  meta_lru;
   logic        wr_en;
   logic [9:0]  wr_index;
   logic [3:0]  wr_way_mask;
   logic [19:0] wr_tag;
   logic [31:0] wr_target;
   logic [1:0]  wr_pred;
   logic        wr_valid;
   logic        lru_wr_en;
   logic [2:0]  lru_wr_data;
   logic        flush_busy;
   logic [15:0] alloc_count;

   int errors = 0;
   int checks = 0;

   btb_update #(.WAYS(4), .SETS(1024)) dut (
      .clk(clk), .rst(rst),
      .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
      .res_target(res_target), .res_taken(res_taken), .flush(flush),
      .meta_rd_en(meta_rd_en), .meta_rd_index(meta_rd_index),
      .meta_tag(meta_tag), .meta_valid(meta_valid), .meta_pred(meta_pred),
      .meta_lru(meta_lru),
      .wr_en(wr_en), .wr_index(wr_index), .wr_way_mask(wr_way_mask),
      .wr_tag(wr_tag), .wr_target(wr_target), .wr_pred(wr_pred),
      .wr_valid(wr_valid), .lru_wr_en(lru_wr_en), .lru_wr_data(lru_wr_data),
      .flush_busy(flush_busy), .alloc_count(alloc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      res_valid  = 1'b1;
      res_pc     = pc;
      res_target = tgt;
      res_taken  = tk;
      step();
      res_valid  = 1'b0;
   endtask

   task automatic set_meta(input logic [79:0] tg, input logic [3:0] vl,
                           input logic [7:0] pr, input logic [2:0] lr);
      meta_tag   = tg;
      meta_valid = vl;
      meta_pred  = pr;
      meta_lru   = lr;
   endtask

   initial begin
      rst = 1'b1;
      res_valid = 1'b0; res_pc = '0; res_target = '0; res_taken = 1'b0;
      flush = 1'b0;
      set_meta('0, '0, '0, '0);
      #1;
      chk("reset_ready", 32'(res_ready), 32'd1);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_rd_en", 32'(meta_rd_en), 32'd0);
      chk("reset_busy", 32'(flush_busy), 32'd0);
      chk("reset_alloc", 32'(alloc_count), 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      // Miss allocate into an empty set
      issue(32'h0000_1004, 32'h0000_2000, 1'b1);
      $display("txn alloc_empty pc=00001004 taken=1");
      chk("alloc_rd_en", 32'(meta_rd_en), 32'd1);
      chk("alloc_rd_index", 32'(meta_rd_index), 32'd1);
      chk("alloc_ready_busy", 32'(res_ready), 32'd0);
      set_meta('0, 4'b0000, 8'h00, 3'b000);
      step();
      chk("alloc_wr_en", 32'(wr_en), 32'd1);
      chk("alloc_wr_index", 32'(wr_index), 32'd1);
      chk("alloc_mask", 32'(wr_way_mask), 32'h1);
      chk("alloc_tag", 32'(wr_tag), 32'h1);
      chk("alloc_target", wr_target, 32'h2000);
      chk("alloc_pred", 32'(wr_pred), 32'd2);
      chk("alloc_valid", 32'(wr_valid), 32'd1);
      chk("alloc_lru_en", 32'(lru_wr_en), 32'd1);
      chk("alloc_lru", 32'(lru_wr_data), 32'b011);
      step();
      chk("alloc_count1", 32'(alloc_count), 32'd1);
      chk("alloc_ready_back", 32'(res_ready), 32'd1);
      chk("alloc_idle_wr", 32'(wr_en), 32'd0);

      // Hit in way2 with saturated counter; way0 tag matches but is invalid
      issue(32'h0000_5008, 32'h0000_ABCD, 1'b1);
      $display("txn hit_sat pc=00005008 taken=1");
      chk("hit_rd_index", 32'(meta_rd_index), 32'd2);
      set_meta({20'h0, 20'h5, 20'h0, 20'h5}, 4'b0100, 8'b00_11_00_00, 3'b011);
      step();
      chk("hit_mask", 32'(wr_way_mask), 32'b0100);
      chk("hit_pred", 32'(wr_pred), 32'd3);
      chk("hit_target", wr_target, 32'h0000_ABCD);
      chk("hit_lru", 32'(lru_wr_data), 32'b110);
      step();
      chk("hit_no_alloc", 32'(alloc_count), 32'd1);

      // Multi-way hit, not taken: lowest way (1) decremented
      issue(32'h0000_5008, 32'h0000_1111, 1'b0);
      $display("txn hit_multi pc=00005008 taken=0");
      set_meta({20'h5, 20'h0, 20'h5, 20'h0}, 4'b1010, 8'b11_00_10_00, 3'b000);
      step();
      chk("multi_wr_en", 32'(wr_en), 32'd1);
      chk("multi_mask", 32'(wr_way_mask), 32'b0010);
      chk("multi_pred", 32'(wr_pred), 32'd1);
      chk("multi_lru", 32'(lru_wr_data), 32'b001);
      step();

      // Full set, no match: PLRU victim way3
      issue(32'h0000_7000, 32'h0000_3000, 1'b1);
      $display("txn victim3 pc=00007000 lru=101");
      set_meta('0, 4'b1111, 8'h00, 3'b101);
      step();
      chk("vic3_mask", 32'(wr_way_mask), 32'b1000);
      chk("vic3_pred", 32'(wr_pred), 32'd2);
      chk("vic3_tag", 32'(wr_tag), 32'h7);
      chk("vic3_lru", 32'(lru_wr_data), 32'b000);
      step();
      chk("vic3_alloc", 32'(alloc_count), 32'd2);

      // Full set, PLRU victim way1
      issue(32'h0000_7004, 32'h0000_3004, 1'b1);
      $display("txn victim1 pc=00007004 lru=010");
      set_meta('0, 4'b1111, 8'h00, 3'b010);
      step();
      chk("vic1_index", 32'(wr_index), 32'd1);
      chk("vic1_mask", 32'(wr_way_mask), 32'b0010);
      chk("vic1_lru", 32'(lru_wr_data), 32'b001);
      step();
      chk("vic1_alloc", 32'(alloc_count), 32'd3);

      // Not-taken miss: no write, ready back three cycles after acceptance
      issue(32'h0000_3010, 32'h0000_4000, 1'b0);
      $display("txn nt_miss pc=00003010 taken=0");
      chk("nt_ready_read", 32'(res_ready), 32'd0);
      set_meta('0, 4'b0011, 8'hFF, 3'b111);
      step();
      chk("nt_wr_en", 32'(wr_en), 32'd0);
      chk("nt_lru_en", 32'(lru_wr_en), 32'd0);
      chk("nt_wr_fields", {wr_way_mask, wr_pred, wr_valid, lru_wr_data, wr_tag[11:0], wr_index},
          32'd0);
      chk("nt_ready_write", 32'(res_ready), 32'd0);
      step();
      chk("nt_ready_back", 32'(res_ready), 32'd1);
      chk("nt_alloc", 32'(alloc_count), 32'd3);

      // Flush and request together: flush wins, then request is taken
      flush = 1'b1;
      res_valid = 1'b1; res_pc = 32'h0000_1008; res_target = 32'h0000_5555; res_taken = 1'b1;
      #1;
      chk("fl_ready_low", 32'(res_ready), 32'd0);
      step();
      flush = 1'b0;
      $display("txn flush_sweep start");
      for (int i = 0; i < 1024; i++) begin
         chk("fl_pulse",
             {wr_en, wr_index, wr_way_mask, wr_valid, lru_wr_en, lru_wr_data, flush_busy, res_ready},
             {1'b1, 10'(i), 4'hF, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0});
         step();
      end
      $display("txn flush_sweep done");
      chk("fl_end_busy", 32'(flush_busy), 32'd0);
      chk("fl_end_wr", 32'(wr_en), 32'd0);
      chk("fl_end_ready", 32'(res_ready), 32'd1);
      step();
      res_valid = 1'b0;
      chk("fl_req_rd_en", 32'(meta_rd_en), 32'd1);
      chk("fl_req_index", 32'(meta_rd_index), 32'd2);
      set_meta('0, 4'b0000, 8'h00, 3'b000);
      step();
      chk("fl_req_mask", 32'(wr_way_mask), 32'b0001);
      chk("fl_req_target", wr_target, 32'h0000_5555);
      step();
      chk("fl_req_alloc", 32'(alloc_count), 32'd4);

      // Reset in the middle of a flush sweep
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (500) step();
      $display("txn flush_reset at index %0d", wr_index);
      chk("rf_index500", 32'(wr_index), 32'd500);
      chk("rf_busy_before", 32'(flush_busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rf_wr_en_async", 32'(wr_en), 32'd0);
      chk("rf_busy_async", 32'(flush_busy), 32'd0);
      chk("rf_alloc_zero", 32'(alloc_count), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("rf_no_resume_wr", 32'(wr_en), 32'd0);
      chk("rf_no_resume_busy", 32'(flush_busy), 32'd0);
      chk("rf_idle_ready", 32'(res_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
